// File: rtl/sd_pkg.sv
// Shared SD definitions: command indices, fixed arguments, error codes and
// the encodings used by the card-identification sequencer.
package sd_pkg;

  localparam logic [5:0] CMD0_IDX   = 6'd0;
  localparam logic [5:0] CMD2_IDX   = 6'd2;
  localparam logic [5:0] CMD3_IDX   = 6'd3;
  localparam logic [5:0] CMD7_IDX   = 6'd7;
  localparam logic [5:0] CMD8_IDX   = 6'd8;
  localparam logic [5:0] ACMD41_IDX = 6'd41;
  localparam logic [5:0] CMD55_IDX  = 6'd55;

  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [11:0] CMD8_ECHO  = 12'h1AA;
  localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_CMD8_ECHO    = 3'd1,
    ERR_ACMD41_TRIES = 3'd2,
    ERR_TIMEOUT      = 3'd3,
    ERR_INDEX        = 3'd4
  } err_code_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWER_WAIT,
    ST_LAUNCH,
    ST_ISSUE,
    ST_BUSY,
    ST_WAIT,
    ST_CHECK,
    ST_TIMEOUT,
    ST_READY,
    ST_ERROR
  } state_e;

  typedef enum logic [2:0] {
    STEP_CMD0,
    STEP_CMD8,
    STEP_CMD55,
    STEP_ACMD41,
    STEP_CMD2,
    STEP_CMD3,
    STEP_CMD7
  } step_e;

  function automatic logic [5:0] step_index(input step_e s);
    logic [5:0] idx;
    unique case (s)
      STEP_CMD0:   idx = CMD0_IDX;
      STEP_CMD8:   idx = CMD8_IDX;
      STEP_CMD55:  idx = CMD55_IDX;
      STEP_ACMD41: idx = ACMD41_IDX;
      STEP_CMD2:   idx = CMD2_IDX;
      STEP_CMD3:   idx = CMD3_IDX;
      STEP_CMD7:   idx = CMD7_IDX;
      default:     idx = CMD0_IDX;
    endcase
    return idx;
  endfunction

  // CMD0 has no response, R3 (ACMD41) and R2 (CMD2) carry no command index.
  function automatic logic index_checked(input step_e s);
    return !(s inside {STEP_CMD0, STEP_ACMD41, STEP_CMD2});
  endfunction

endpackage

// File: rtl/sd_timeout_cnt.sv
// Loadable saturating down-counter; expired is high while the count is zero.
module sd_timeout_cnt #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sd_init_seq.sv
// SD card-identification sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2,
// CMD3, CMD7, driving the CMD-line driver and reporting card parameters.
module sd_init_seq
  import sd_pkg::*;
#(
  parameter int INIT_CLKS    = 80,
  parameter int TIMEOUT_CLKS = 1024,
  parameter int ACMD41_TRIES = 1000
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         istart,
  output logic         ostart_cmd,
  output logic [5:0]   ocmd_index,
  output logic [31:0]  ocmd_arg,
  input  logic [119:0] iresp,
  input  logic         icmd_done,
  output logic         ocmd_rst,
  output logic         oready,
  output logic         oerror,
  output logic [2:0]   oerr_code,
  output logic [15:0]  orca,
  output logic         ohcs,
  output logic [119:0] ocid
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int RW = $clog2(ACMD41_TRIES + 1);

  state_e         state;
  step_e          step;
  logic [RW-1:0]  retry_cnt;
  logic [RW-1:0]  retry_next;
  logic           busy_wait;
  logic           tmr_load;
  logic           tmr_en;
  logic           tmr_expired;
  logic [TW-1:0]  tmr_val;
  logic [31:0]    step_arg;
  err_code_e      chk_err;

  // One timer serves both the power-up wait and the per-command timeout:
  // parked at INIT_CLKS while idle, reloaded with TIMEOUT_CLKS during ISSUE.
  assign tmr_load = state inside {ST_IDLE, ST_READY, ST_ERROR, ST_ISSUE};
  assign tmr_en   = state inside {ST_POWER_WAIT, ST_BUSY, ST_WAIT};
  assign tmr_val  = (state == ST_ISSUE) ? TW'(TIMEOUT_CLKS) : TW'(INIT_CLKS);

  sd_timeout_cnt #(.WIDTH(TW)) u_timer (
    .clk      (iclk),
    .rst      (irst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  assign retry_next = retry_cnt + 1'b1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    step_arg = 32'h0;
    unique case (step)
      STEP_CMD8:   step_arg = CMD8_ARG;
      STEP_ACMD41: step_arg = ACMD41_ARG;
      STEP_CMD7:   step_arg = {orca, 16'h0};
      default:     step_arg = 32'h0;
    endcase
  end

  always_comb begin
    chk_err = ERR_NONE;
    if (index_checked(step) && iresp[37:32] != step_index(step)) begin
      chk_err = ERR_INDEX;
    end else if (step == STEP_CMD8 && iresp[11:0] != CMD8_ECHO) begin
      chk_err = ERR_CMD8_ECHO;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state      <= ST_IDLE;
      step       <= STEP_CMD0;
      retry_cnt  <= '0;
      busy_wait  <= 1'b0;
      ostart_cmd <= 1'b0;
      ocmd_index <= '0;
      ocmd_arg   <= '0;
      ocmd_rst   <= 1'b0;
      oready     <= 1'b0;
      oerror     <= 1'b0;
      oerr_code  <= ERR_NONE;
      orca       <= '0;
      ohcs       <= 1'b0;
      ocid       <= '0;
    end else begin
      ostart_cmd <= 1'b0;
      ocmd_rst   <= 1'b0;
      unique case (state)
        ST_IDLE, ST_READY, ST_ERROR: begin
          if (istart) begin
            state     <= ST_POWER_WAIT;
            step      <= STEP_CMD0;
            retry_cnt <= '0;
            oready    <= 1'b0;
            oerror    <= 1'b0;
            oerr_code <= ERR_NONE;
            orca      <= '0;
            ohcs      <= 1'b0;
            ocid      <= '0;
          end
        end

        ST_POWER_WAIT: begin
          if (tmr_expired) state <= ST_LAUNCH;
        end

        ST_LAUNCH: begin
          ostart_cmd <= 1'b1;
          ocmd_index <= step_index(step);
          ocmd_arg   <= step_arg;
          busy_wait  <= 1'b0;
          state      <= ST_ISSUE;
        end

        ST_ISSUE: state <= ST_BUSY;

        // A fast driver may never be seen busy; give it two cycles at most.
        ST_BUSY: begin
          if (tmr_expired) begin
            state    <= ST_TIMEOUT;
            ocmd_rst <= 1'b1;
          end else if (!icmd_done || busy_wait) begin
            state <= ST_WAIT;
          end else begin
            busy_wait <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (tmr_expired) begin
            state    <= ST_TIMEOUT;
            ocmd_rst <= 1'b1;
          end else if (icmd_done) begin
            state <= ST_CHECK;
          end
        end

        ST_TIMEOUT: begin
          if (step == STEP_CMD0) begin
            step  <= STEP_CMD8;
            state <= ST_LAUNCH;
          end else begin
            state     <= ST_ERROR;
            oerror    <= 1'b1;
            oerr_code <= ERR_TIMEOUT;
          end
        end

        ST_CHECK: begin
          if (chk_err != ERR_NONE) begin
            state     <= ST_ERROR;
            oerror    <= 1'b1;
            oerr_code <= chk_err;
          end else begin
            state <= ST_LAUNCH;
            unique case (step)
              STEP_CMD0:  step <= STEP_CMD8;
              STEP_CMD8:  step <= STEP_CMD55;
              STEP_CMD55: step <= STEP_ACMD41;
              STEP_ACMD41: begin
                if (iresp[31]) begin
                  ohcs <= iresp[30];
                  step <= STEP_CMD2;
                end else begin
                  retry_cnt <= retry_next;
                  if (retry_next >= RW'(ACMD41_TRIES)) begin
                    state     <= ST_ERROR;
                    oerror    <= 1'b1;
                    oerr_code <= ERR_ACMD41_TRIES;
                  end else begin
                    step <= STEP_CMD55;
                  end
                end
              end
              STEP_CMD2: begin
                ocid <= iresp;
                step <= STEP_CMD3;
              end
              STEP_CMD3: begin
                orca <= iresp[31:16];
                step <= STEP_CMD7;
              end
              STEP_CMD7: begin
                state  <= ST_READY;
                oready <= 1'b1;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_seq.sv
// Directed bench for sd_init_seq: a small card model answers the driver
// interface; scenario table plus hand-written reset/restart sequences.
module tb_sd_init_seq;

  localparam int INIT_CLKS    = 80;
  localparam int TIMEOUT_CLKS = 1024;
  localparam int TRIES        = 4;
  localparam logic [119:0] CID = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
  localparam logic [15:0]  RCA = 16'h1234;

  logic         iclk = 1'b0;
  logic         irst;
  logic         istart;
  logic         ostart_cmd;
  logic [5:0]   ocmd_index;
  logic [31:0]  ocmd_arg;
  logic [119:0] iresp;
  logic         icmd_done;
  logic         ocmd_rst;
  logic         oready;
  logic         oerror;
  logic [2:0]   oerr_code;
  logic [15:0]  orca;
  logic         ohcs;
  logic [119:0] ocid;

  sd_init_seq #(
    .INIT_CLKS    (INIT_CLKS),
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .ACMD41_TRIES (TRIES)
  ) dut (
    .iclk       (iclk),
    .irst       (irst),
    .istart     (istart),
    .ostart_cmd (ostart_cmd),
    .ocmd_index (ocmd_index),
    .ocmd_arg   (ocmd_arg),
    .iresp      (iresp),
    .icmd_done  (icmd_done),
    .ocmd_rst   (ocmd_rst),
    .oready     (oready),
    .oerror     (oerror),
    .oerr_code  (oerr_code),
    .orca       (orca),
    .ohcs       (ohcs),
    .ocid       (ocid)
  );

  always #5 iclk = ~iclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Card behaviour knobs
  int          cfg_silent = -1;
  int          cfg_bad    = -1;
  logic [11:0] cfg_echo   = 12'h1AA;
  int          cfg_busy   = 0;
  bit          cfg_hcs    = 1'b1;
  int          acmd41_seen = 0;

  logic [5:0]  cmd_idx_q[$];
  logic [31:0] cmd_arg_q[$];
  int          rst_count = 0;
  int          rst_delay = 0;
  int          last_start_cyc = 0;

  typedef struct {
    string       name;
    int          silent;
    int          bad;
    logic [11:0] echo;
    int          busy;
    bit          hcs;
    bit          exp_ready;
    bit          exp_error;
    logic [2:0]  exp_code;
    logic [15:0] exp_rca;
    bit          exp_hcs;
    int          exp_ncmd;
    int          exp_rst;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s ready", tag),   oready,     1'b0);
    check($sformatf("%s error", tag),   oerror,     1'b0);
    check($sformatf("%s code", tag),    oerr_code,  3'd0);
    check($sformatf("%s rca", tag),     orca,       16'h0);
    check($sformatf("%s hcs", tag),     ohcs,       1'b0);
    check($sformatf("%s cid", tag),     ocid,       120'h0);
    check($sformatf("%s start", tag),   ostart_cmd, 1'b0);
    check($sformatf("%s cmd_rst", tag), ocmd_rst,   1'b0);
    check($sformatf("%s index", tag),   ocmd_index, 6'h0);
    check($sformatf("%s arg", tag),     ocmd_arg,   32'h0);
  endtask

  function automatic vec_t mk(string n, int sil, int bad, logic [11:0] echo, int busy, bit hcs,
                              bit er, bit ee, logic [2:0] code, logic [15:0] rca, bit eh,
                              int nc, int nr);
    vec_t v;
    v.name = n; v.silent = sil; v.bad = bad; v.echo = echo; v.busy = busy; v.hcs = hcs;
    v.exp_ready = er; v.exp_error = ee; v.exp_code = code; v.exp_rca = rca; v.exp_hcs = eh;
    v.exp_ncmd = nc; v.exp_rst = nr;
    return v;
  endfunction

  function automatic logic [31:0] arg_for(input logic [5:0] idx);
    case (idx)
      6'd8:    return 32'h0000_01AA;
      6'd41:   return 32'h40FF_8000;
      6'd7:    return {RCA, 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge iclk) cyc++;

  // Driver/card model: goes busy when a command is launched, answers 3 cycles later.
  logic [5:0]  cidx;
  logic [5:0]  ridx;
  logic [31:0] pl;
  initial begin : card
    forever begin
      @(negedge iclk);
      if (ostart_cmd && !irst) begin
        cidx = ocmd_index;
        cmd_idx_q.push_back(ocmd_index);
        cmd_arg_q.push_back(ocmd_arg);
        icmd_done = 1'b0;
        if (int'(cidx) == cfg_silent) begin
          while (!ocmd_rst && !irst) @(negedge iclk);
        end else begin
          for (int k = 0; k < 3; k++) @(negedge iclk);
          ridx = (cidx == 6'd41) ? 6'h3F : cidx;
          if (int'(cidx) == cfg_bad) ridx = ridx ^ 6'h1;
          case (cidx)
            6'd8:    pl = {20'h0, cfg_echo};
            6'd55:   pl = 32'h0000_0120;
            6'd41:   pl = (acmd41_seen < cfg_busy) ? 32'h00FF_8000 : {1'b1, cfg_hcs, 30'h00FF_8000};
            6'd3:    pl = {RCA, 16'h0500};
            6'd7:    pl = 32'h0000_0900;
            default: pl = 32'h0;
          endcase
          if (cidx == 6'd41) acmd41_seen++;
          iresp = (cidx == 6'd2) ? CID : {82'h0, ridx, pl};
        end
        icmd_done = 1'b1;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge iclk);
      if (ostart_cmd) last_start_cyc = cyc;
      if (ocmd_rst) begin
        rst_count++;
        rst_delay = cyc - last_start_cyc;
      end
    end
  end

  task automatic pulse_start();
    istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge iclk);
      if (oready || oerror) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    cmd_idx_q.delete();
    cmd_arg_q.delete();
    rst_count   = 0;
    acmd41_seen = 0;
  endtask

  initial begin : main
    vec_t vecs[7];
    vec_t v;
    bit   ok;
    int   exp_seq[$];
    int   pairs;
    int   n;
    int   t0;
    bit   seen;

    istart    = 1'b0;
    icmd_done = 1'b1;
    iresp     = '0;
    irst      = 1'b1;
    repeat (3) @(negedge iclk);
    check_all_zero("reset");
    irst = 1'b0;
    repeat (5) @(negedge iclk);
    check("idle no start", ostart_cmd, 1'b0);

    //            name         sil bad echo     busy hcs rdy err code rca  hcs ncmd rst
    vecs[0] = mk("happy",      -1, -1, 12'h1AA,  3,   1,  1,  0,  0,  RCA, 1,  13,  0);
    vecs[1] = mk("cmd0_quiet",  0, -1, 12'h1AA,  3,   1,  1,  0,  0,  RCA, 1,  13,  1);
    vecs[2] = mk("cmd8_echo",  -1, -1, 12'h155,  3,   1,  0,  1,  1,  0,   0,   2,  0);
    vecs[3] = mk("acmd41_max", -1, -1, 12'h1AA, 1000, 1,  0,  1,  2,  0,   0,  10,  0);
    vecs[4] = mk("cmd3_tout",   3, -1, 12'h1AA,  3,   1,  0,  1,  3,  0,   1,  12,  1);
    vecs[5] = mk("sdsc",       -1, -1, 12'h1AA,  0,   0,  1,  0,  0,  RCA, 0,   7,  0);
    vecs[6] = mk("bad_index",  -1, 55, 12'h1AA,  3,   1,  0,  1,  4,  0,   0,   3,  0);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      cfg_silent = v.silent;
      cfg_bad    = v.bad;
      cfg_echo   = v.echo;
      cfg_busy   = v.busy;
      cfg_hcs    = v.hcs;
      clear_log();
      pulse_start();
      check($sformatf("%s cleared ready", v.name), oready, 1'b0);
      check($sformatf("%s cleared error", v.name), oerror, 1'b0);
      check($sformatf("%s cleared code", v.name), oerr_code, 3'd0);
      check($sformatf("%s cleared rca", v.name), orca, 16'h0);
      wait_result(ok);
      check($sformatf("%s finished", v.name), ok, 1'b1);
      repeat (20) @(negedge iclk);
      check($sformatf("%s ready", v.name), oready, v.exp_ready);
      check($sformatf("%s error", v.name), oerror, v.exp_error);
      check($sformatf("%s code", v.name), oerr_code, v.exp_code);
      check($sformatf("%s rca", v.name), orca, v.exp_rca);
      check($sformatf("%s hcs", v.name), ohcs, v.exp_hcs);
      if (v.exp_ready) check($sformatf("%s cid", v.name), ocid, CID);
      check($sformatf("%s cmd count", v.name), cmd_idx_q.size(), v.exp_ncmd);
      check($sformatf("%s rst pulses", v.name), rst_count, v.exp_rst);
      if (rst_count > 0)
        check_range($sformatf("%s rst delay", v.name), rst_delay, TIMEOUT_CLKS, TIMEOUT_CLKS + 8);

      exp_seq.delete();
      exp_seq.push_back(0);
      exp_seq.push_back(8);
      pairs = (v.busy + 1 < TRIES) ? v.busy + 1 : TRIES;
      for (int p = 0; p < pairs; p++) begin
        exp_seq.push_back(55);
        exp_seq.push_back(41);
      end
      exp_seq.push_back(2);
      exp_seq.push_back(3);
      exp_seq.push_back(7);
      n = (cmd_idx_q.size() < v.exp_ncmd) ? cmd_idx_q.size() : v.exp_ncmd;
      for (int k = 0; k < n; k++) begin
        check($sformatf("%s cmd%0d index", v.name, k), cmd_idx_q[k], exp_seq[k]);
        check($sformatf("%s cmd%0d arg", v.name, k), cmd_arg_q[k], arg_for(6'(exp_seq[k])));
      end
    end

    // Reset while CMD2 sits in WAIT, then restart (second istart ignored).
    cfg_silent = 2; cfg_bad = -1; cfg_echo = 12'h1AA; cfg_busy = 0; cfg_hcs = 1'b1;
    clear_log();
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge iclk);
      if (cmd_idx_q.size() > 0 && cmd_idx_q[cmd_idx_q.size()-1] == 6'd2) seen = 1'b1;
    end
    check("cmd2 reached", seen, 1'b1);
    repeat (10) @(negedge iclk);
    check("cmd2 pending hcs", ohcs, 1'b1);
    irst = 1'b1;
    @(posedge iclk);
    #1;
    check_all_zero("rst_in_cmd2");
    @(negedge iclk);
    irst = 1'b0;
    cfg_silent = -1;
    repeat (3) @(negedge iclk);
    clear_log();
    t0 = cyc;
    pulse_start();
    seen = 1'b0;
    n = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      istart = (c == 20);
      @(negedge iclk);
      if (ostart_cmd) begin
        seen = 1'b1;
        n = cyc - t0;
        check("restart first index", ocmd_index, 6'd0);
      end
    end
    istart = 1'b0;
    check("restart issued", seen, 1'b1);
    check_range("restart init delay", n, INIT_CLKS, INIT_CLKS + 8);
    wait_result(ok);
    check("restart finished", ok, 1'b1);
    check("restart ready", oready, 1'b1);

    // Reset landing while the start pulse is high drops it at once.
    clear_log();
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge iclk);
      if (ostart_cmd) seen = 1'b1;
    end
    check("pulse seen", seen, 1'b1);
    irst = 1'b1;
    #1;
    check("async start drop", ostart_cmd, 1'b0);
    check("async index clear", ocmd_index, 6'd0);
    @(negedge iclk);
    irst = 1'b0;
    repeat (5) @(negedge iclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
